ldpc_dec_engine_sched: RTL
==========================

// Module: ldpc_dec_engine_sched
// PURPOSE
//  Frame scheduler sharing one input buffer and one output port between pENGINE_NUM LDPC decoder engines.
//  - Dispatches each full input frame to the next engine in cyclic order and pulses the engine start.
//  - Releases the input buffer once the engine has taken the frame.
//  - Presents decoded frames to the output port strictly in dispatch order, together with tag and decfail.
//  - Sits between the input ping-pong buffer, the decoder engines and the output mux.
// PARAMETERS
//  pENGINE_NUM  2  number of decoder engines, >= 2
//  pTAG_W       4  width of the user frame tag carried with each frame
// PORTS
//  iclk           in   1            clock
//  ireset         in   1            synchronous active-high reset
//  iclkena        in   1            clock enable; all state holds when 0
//  ibuf_full      in   1            input buffer holds a complete frame
//  ibuf_tag       in   pTAG_W       tag of that frame
//  obuf_rempty    out  1            one-cycle pulse: frame consumed, buffer may be refilled
//  oeng_start     out  pENGINE_NUM  one-hot, one-cycle start pulse to the selected engine
//  ieng_done      in   pENGINE_NUM  per-engine one-cycle pulse: decoding finished
//  ieng_decfail   in   pENGINE_NUM  per-engine decode-fail flag, sampled together with ieng_done
//  oout_val       out  1            head-of-order frame ready at output
//  oout_sel       out  cIDX_W       engine index driving the output mux
//  oout_tag       out  pTAG_W       tag of the output frame
//  oout_decfail   out  1            decfail of the output frame
//  iout_ack       in   1            output frame fully read; engine is released
// BEHAVIOUR
//  - Reset is synchronous, takes priority over iclkena, and is valid mid-frame.
//  - Reset clears all slots and pointers; every output resets to 0.
//  - Per engine i, the slot holds {busy, done, decfail, tag}.
//    - Start of i sets busy, clears done and latches tag.
//    - ieng_done[i] & busy sets done and latches decfail.
//    - ieng_done[i] while !busy is ignored.
//    - Ack of i clears busy and done.
//  - wr_ptr and rd_ptr are cIDX_W counters that wrap pENGINE_NUM-1 -> 0.
//  - Dispatch FSM:
//    - cRESET -> cWAIT.
//    - cWAIT -> cSTART when ibuf_full & !busy[wr_ptr].
//    - cSTART -> cRELEASE.
//    - cRELEASE -> cWAIT.
//  - Registered outputs, decoded from next_state:
//    - oeng_start[wr_ptr] is high for the one cycle the FSM is in cSTART. Tag and busy are written on that edge.
//    - obuf_rempty is high for the one cycle in cRELEASE. wr_ptr increments on the same edge.
//  - Latency from ibuf_full with a free engine: start 1 cycle later, obuf_rempty 2 cycles later.
//  - A new start is possible at most every 3 cycles.
//  - The FSM waits in cWAIT while every engine is busy. Output back-pressure holds engines busy, and that stalls input.
//  - Output:
//    - oout_val = busy[rd_ptr] & done[rd_ptr], registered.
//    - oout_sel = rd_ptr. oout_tag and oout_decfail come from slot rd_ptr.
//    - iout_ack is honoured only while oout_val=1, otherwise it is ignored.
//    - On ack: the slot is cleared, rd_ptr wraps to the next value, and oout_val drops for at least 1 cycle.
//    - Out-of-order completions are held until their turn.
//  - Simultaneous events:
//    - Start, done and ack on different engines in the same cycle are all applied.
//    - Ack of engine k in the cycle cWAIT tests busy[k] is not seen; dispatch to k follows one cycle later.
// CONFIGURATION
//  - LDPC_DEC_SCHED_STAT_EN defined: adds ports ostat_frames and ostat_fails (each 16 bit, out).
//    - They are saturating counters of acked frames and of acked frames with decfail=1.
//    - Both reset to 0.
//  - Undefined: no such ports and no counter logic.
// STRUCTURE
//  - ldpc_dec_sched_pkg holds:
//    - cIDX_W = (pENGINE_NUM > 1) ? $clog2(pENGINE_NUM) : 1
//    - slot_t struct {busy, done, decfail, tag}
//    - the state enum
//  - Sub-module ldpc_dec_sched_slot: one slot's flag/tag register with set/clear priority. Instantiated pENGINE_NUM times via generate.
//  - Top level holds the FSM, the pointers and the output registers.
// TESTING
//  1. Reset, ibuf_full=1 with tag 3:
//     - oeng_start=01 at cycle 1, obuf_rempty at cycle 2.
//     - done[0] -> oout_val=1, sel=0, tag=3.
//  2. Three frames with tags 1/2/3 and acks withheld:
//     - starts go to engine 0 then 1.
//     - the third frame stalls with obuf_rempty=0 until ack of engine 0, then starts on engine 0.
//  3. done[1] before done[0]:
//     - oout_val stays 0 until done[0].
//     - output order is sel 0, then 1.
//  4. Decfail on engine 1 (ieng_decfail[1]=1 with done[1]):
//     - oout_decfail=1 only when sel=1.
//     - with STAT_EN: frames=2, fails=1 after both acks.
//  5. iclkena=0 for 5 cycles during cSTART:
//     - oeng_start is held with no extra pulse.
//     - a mid-frame ireset returns all outputs to 0 on the next edge.
//  6. Spurious iout_ack with oout_val=0 and spurious ieng_done on an idle engine: no state change.

Source files
------------

// File: rtl/ldpc_dec_sched_pkg.sv
// ldpc_dec_sched_pkg
//   Shared types and helpers for the LDPC decoder engine scheduler.
//   - cidx_w()  : width of an engine index (cIDX_W), at least 1 bit
//   - state_t   : dispatch FSM states
//   - slot_t    : per-engine bookkeeping flags {busy, done, decfail}. The tag
//                 lives beside the flags in the slot module because its width
//                 follows the scheduler's pTAG_W parameter.
package ldpc_dec_sched_pkg;

  function automatic int cidx_w(input int engine_num);
    return (engine_num > 1) ? $clog2(engine_num) : 1;
  endfunction

  typedef enum logic [1:0] {
    cRESET   = 2'd0,
    cWAIT    = 2'd1,
    cSTART   = 2'd2,
    cRELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic decfail;
  } slot_t;

endpackage

// File: rtl/ldpc_dec_sched_slot.sv
// ldpc_dec_sched_slot
//   Bookkeeping register for one decoder engine.
//   Ports:
//     iclk, ireset, iclkena : clock, synchronous active-high reset, clock enable
//     istart, itag          : engine started; latch the frame tag
//     idone, idecfail       : engine finished; decfail sampled with done
//     iack                  : output side has read the frame; free the engine
//     oslot, otag           : current flags and tag
//   Priority: start overrides everything; ack overrides done.
module ldpc_dec_sched_slot
  import ldpc_dec_sched_pkg::*;
#(
  parameter int pTAG_W = 4
)
(
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              istart,
  input  logic [pTAG_W-1:0] itag,
  input  logic              idone,
  input  logic              idecfail,
  input  logic              iack,
  output slot_t             oslot,
  output logic [pTAG_W-1:0] otag
);

  slot_t             slot_reg, slot_next;
  logic [pTAG_W-1:0] tag_reg, tag_next;

  always_comb begin
    slot_next = slot_reg;
    tag_next  = tag_reg;
    if (iack) begin
      slot_next.busy = 1'b0;
      slot_next.done = 1'b0;
    end else if (idone && slot_reg.busy) begin
      // done on an idle engine is a stray pulse and is dropped
      slot_next.done    = 1'b1;
      slot_next.decfail = idecfail;
    end
    if (istart) begin
      slot_next.busy    = 1'b1;
      slot_next.done    = 1'b0;
      slot_next.decfail = 1'b0;
      tag_next          = itag;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      slot_reg <= '0;
      tag_reg  <= '0;
    end else if (iclkena) begin
      slot_reg <= slot_next;
      tag_reg  <= tag_next;
    end
  end

  assign oslot = slot_reg;
  assign otag  = tag_reg;

endmodule

// File: rtl/ldpc_dec_engine_sched.sv
// ldpc_dec_engine_sched
//   Shares one input buffer and one output port between pENGINE_NUM LDPC
//   decoder engines. Frames go to engines in cyclic order and leave in the
//   same order, with their tag and decfail.
//   Ports:
//     iclk, ireset, iclkena         : clock, sync active-high reset, clock enable
//     ibuf_full, ibuf_tag           : input buffer has a frame, and its tag
//     obuf_rempty                   : pulse, input buffer consumed
//     oeng_start                    : one-hot start pulse to an engine
//     ieng_done, ieng_decfail       : per-engine completion and fail flag
//     oout_val/sel/tag/decfail      : head-of-order frame at the output
//     iout_ack                      : output frame read, engine released
//   Optional build macro LDPC_DEC_SCHED_STAT_EN adds ostat_frames and
//   ostat_fails (saturating counts of acked frames / acked failed frames).
module ldpc_dec_engine_sched
  import ldpc_dec_sched_pkg::*;
#(
  parameter  int pENGINE_NUM = 2,
  parameter  int pTAG_W      = 4,
  localparam int cIDX_W      = cidx_w(pENGINE_NUM)
)
(
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   iclkena,
  input  logic                   ibuf_full,
  input  logic [pTAG_W-1:0]      ibuf_tag,
  output logic                   obuf_rempty,
  output logic [pENGINE_NUM-1:0] oeng_start,
  input  logic [pENGINE_NUM-1:0] ieng_done,
  input  logic [pENGINE_NUM-1:0] ieng_decfail,
  output logic                   oout_val,
  output logic [cIDX_W-1:0]      oout_sel,
  output logic [pTAG_W-1:0]      oout_tag,
  output logic                   oout_decfail,
  input  logic                   iout_ack
`ifdef LDPC_DEC_SCHED_STAT_EN
  ,
  output logic [15:0]            ostat_frames,
  output logic [15:0]            ostat_fails
`endif
);

  localparam logic [cIDX_W-1:0] cLAST = cIDX_W'(pENGINE_NUM - 1);

  function automatic logic [cIDX_W-1:0] ptr_inc(input logic [cIDX_W-1:0] p);
    return (p == cLAST) ? '0 : p + 1'b1;
  endfunction

  state_t                  state_reg, state_next;
  logic [cIDX_W-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [cIDX_W-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [pENGINE_NUM-1:0]  start_reg, start_next;
  logic                    rempty_reg, rempty_next;
  logic                    val_reg, val_next;
  logic [cIDX_W-1:0]       sel_reg;
  logic [pTAG_W-1:0]       tag_reg;
  logic                    decfail_reg;
  logic                    ack_take;
  logic [pENGINE_NUM-1:0]  ack_vec;

  slot_t                   slot     [pENGINE_NUM];
  logic [pTAG_W-1:0]       slot_tag [pENGINE_NUM];

  generate
    for (genvar gi = 0; gi < pENGINE_NUM; gi++) begin : g_slot
      ldpc_dec_sched_slot #(.pTAG_W(pTAG_W)) u_slot (
        .iclk     (iclk),
        .ireset   (ireset),
        .iclkena  (iclkena),
        .istart   (start_next[gi]),
        .itag     (ibuf_tag),
        .idone    (ieng_done[gi]),
        .idecfail (ieng_decfail[gi]),
        .iack     (ack_vec[gi]),
        .oslot    (slot[gi]),
        .otag     (slot_tag[gi])
      );
    end
  endgenerate

  // Next-state logic. busy is the registered value, so an ack landing in the
  // same cycle is only seen one cycle later.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      cRESET:   state_next = cWAIT;
      cWAIT:    if (ibuf_full && !slot[wr_ptr_reg].busy) state_next = cSTART;
      cSTART:   state_next = cRELEASE;
      cRELEASE: state_next = cWAIT;
      default:  state_next = cRESET;
    endcase
  end

  // Output decode from next_state, plus pointer and output-port next values.
  always_comb begin
    start_next = '0;
    if (state_next == cSTART) start_next[wr_ptr_reg] = 1'b1;
    rempty_next = (state_next == cRELEASE);
    wr_ptr_next = (state_next == cRELEASE) ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;

    // An ack only counts against a frame actually being presented.
    ack_take = iout_ack & val_reg;
    ack_vec  = '0;
    ack_vec[rd_ptr_reg] = ack_take;
    rd_ptr_next = ack_take ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    // Forcing val low on ack guarantees a gap cycle between frames.
    val_next = !ack_take && slot[rd_ptr_reg].busy && slot[rd_ptr_reg].done;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_reg   <= cRESET;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      start_reg   <= '0;
      rempty_reg  <= 1'b0;
      val_reg     <= 1'b0;
      sel_reg     <= '0;
      tag_reg     <= '0;
      decfail_reg <= 1'b0;
    end else if (iclkena) begin
      state_reg   <= state_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      start_reg   <= start_next;
      rempty_reg  <= rempty_next;
      val_reg     <= val_next;
      sel_reg     <= rd_ptr_reg;
      tag_reg     <= slot_tag[rd_ptr_reg];
      decfail_reg <= slot[rd_ptr_reg].decfail;
    end
  end

  assign oeng_start   = start_reg;
  assign obuf_rempty  = rempty_reg;
  assign oout_val     = val_reg;
  assign oout_sel     = sel_reg;
  assign oout_tag     = tag_reg;
  assign oout_decfail = decfail_reg;

`ifdef LDPC_DEC_SCHED_STAT_EN
  logic [15:0] stat_frames_reg;
  logic [15:0] stat_fails_reg;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      stat_frames_reg <= '0;
      stat_fails_reg  <= '0;
    end else if (iclkena && ack_take) begin
      if (stat_frames_reg != 16'hFFFF) stat_frames_reg <= stat_frames_reg + 16'd1;
      if (decfail_reg && stat_fails_reg != 16'hFFFF) stat_fails_reg <= stat_fails_reg + 16'd1;
    end
  end

  assign ostat_frames = stat_frames_reg;
  assign ostat_fails  = stat_fails_reg;
`endif

endmodule
